// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster constants, total helper and sync bundle type
package vga_timing_pkg;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    localparam int VGA800_H_ACTIVE = 800;
    localparam int VGA800_H_FP     = 40;
    localparam int VGA800_H_SYNC   = 128;
    localparam int VGA800_H_BP     = 88;
    localparam int VGA800_V_ACTIVE = 600;
    localparam int VGA800_V_FP     = 1;
    localparam int VGA800_V_SYNC   = 4;
    localparam int VGA800_V_BP     = 23;

    localparam int VGA320_H_ACTIVE = 320;
    localparam int VGA320_H_FP     = 8;
    localparam int VGA320_H_SYNC   = 48;
    localparam int VGA320_H_BP     = 24;
    localparam int VGA320_V_ACTIVE = 240;
    localparam int VGA320_V_FP     = 5;
    localparam int VGA320_V_SYNC   = 1;
    localparam int VGA320_V_BP     = 16;

    function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef struct packed {
        logic hs;
        logic vs;
        logic bright;
    } sync_bits_t;

endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - PIPE-stage tick-gated delay for the sync/blank bundle
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int PIPE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  sync_bits_t d,
    output sync_bits_t q
);

    generate
        if (PIPE == 0) begin : g_wire
            logic unused_ports;
            assign unused_ports = clk ^ rst_n ^ en;
            assign q = d;
        end else begin : g_pipe
            sync_bits_t stage [PIPE];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) stage[i] <= '0;
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[PIPE-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with pixel tick and sync delay
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int PIPE     = 0,
    parameter int CW       = 10
) (
    input  logic          clk_50,
    input  logic          reset_n,
    input  logic          enable,
    output logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          h_sync,
    output logic          v_sync,
    output logic          bright,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYN_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYN_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYN_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYN_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]    DIV_LAST   = 4'(CLK_DIV - 1);

    generate
        if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_width
            $error("vga_timing_gen: raster totals do not fit in CW bits");
        end
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1) begin : g_bad_timing
            $error("vga_timing_gen: every timing parameter must be at least 1");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16 || PIPE < 0 || PIPE > 7) begin : g_bad_range
            $error("vga_timing_gen: CLK_DIV or PIPE out of range");
        end
    endgenerate

    logic [3:0]    div_cnt;
    logic [3:0]    div_next;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    sync_bits_t    raw_next;
    sync_bits_t    raw_q;
    sync_bits_t    dly_q;

    assign div_next = (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;

    // pix_en is registered from the next divider value so it lines up with div_cnt == CLK_DIV-1
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= 4'd0;
            pix_en  <= 1'b0;
        end else begin
            div_cnt <= div_next;
            pix_en  <= (div_next == DIV_LAST);
        end
    end

    // Stopped raster parks at the last position so the next running tick lands on (0,0)
    always_comb begin
        h_next = (h_count == H_LAST) ? '0 : h_count + 1'b1;
        v_next = v_count;
        if (h_count == H_LAST) begin
            v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end
        if (!enable) begin
            h_next = H_LAST;
            v_next = V_LAST;
        end
        raw_next.hs     = (h_next >= H_SYN_BEG) && (h_next < H_SYN_END);
        raw_next.vs     = (v_next >= V_SYN_BEG) && (v_next < V_SYN_END);
        raw_next.bright = (h_next < H_ACT_END) && (v_next < V_ACT_END);
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            raw_q       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                h_count     <= h_next;
                v_count     <= v_next;
                raw_q       <= raw_next;
                line_start  <= enable && (h_next == '0);
                frame_start <= enable && (h_next == '0) && (v_next == '0);
            end
        end
    end

    vga_sync_delay #(
        .PIPE (PIPE)
    ) u_sync_delay (
        .clk   (clk_50),
        .rst_n (reset_n),
        .en    (pix_en),
        .d     (raw_q),
        .q     (dly_q)
    );

    assign h_sync = dly_q.hs ? H_POL : ~H_POL;
    assign v_sync = dly_q.vs ? V_POL : ~V_POL;
    assign bright = dly_q.bright;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the next-generation replacement for the fixed 640x480 `vga_control` unit. It runs on the system clock and produces its own pixel-rate clock enable, so no separate divider block is needed. It provides horizontal and vertical counters, sync pulses with configurable polarity, an active-video `bright` flag, and line/frame start strobes. Sync and blanking outputs pass through a configurable delay so they stay aligned with the latency of the display and frame-buffer pipeline.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, h_sync active level (0 = active-low)
- `V_POL`, 0, v_sync active level
- `CLK_DIV`, 2, system clocks per pixel, range 1..16
- `PIPE`, 0, pixel-tick delay applied to h_sync, v_sync and bright, range 0..7
- `CW`, 10, counter width
- `clk_50` in 1: system clock
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: run/stop control for the raster
- `pix_en` out 1: pixel-rate clock enable
- `h_count` out CW: current pixel column
- `v_count` out CW: current line
- `h_sync` out 1: horizontal sync
- `v_sync` out 1: vertical sync
- `bright` out 1: active-video flag
- `line_start` out 1: one-clock strobe at the start of each line
- `frame_start` out 1: one-clock strobe at the start of each frame

## Operation
- Line and frame lengths: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is formed the same way from the V_ parameters.
- Region order within a line or frame: active, front porch, sync, back porch.
- Divider: `div_cnt` counts 0..CLK_DIV-1.
  - `pix_en` is a register that is high for one clock when `div_cnt` = CLK_DIV-1.
  - With CLK_DIV=1, `pix_en` is held high continuously after reset.
- Counters update only on edges where `pix_en`=1.
  - `h_count` wraps from H_TOTAL-1 to 0.
  - `v_count` increments only on an `h_count` wrap, and wraps from V_TOTAL-1 to 0.
- Decode, before the delay line:
  - hs_raw is active when H_ACTIVE+H_FP ≤ `h_count` < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is active when V_ACTIVE+V_FP ≤ `v_count` < V_ACTIVE+V_FP+V_SYNC.
  - bright_raw = (`h_count` < H_ACTIVE) && (`v_count` < V_ACTIVE).
- Decode is computed from the next-count values and registered together with the counts, so with PIPE=0 the outputs agree with the counts in every cycle.
- Delay line: a PIPE-stage shift register, advanced on `pix_en` and holding `{hs, vs, bright}`. Counts and strobes are not delayed.
- Polarity: `h_sync` = hs_raw ? H_POL : !H_POL. `v_sync` uses V_POL the same way.
- Strobes:
  - `line_start` is high for the single clock after an update edge that set `h_count` to 0.
  - `frame_start` is high for the single clock after an update edge that set both counts to 0.
- `enable`:
  - When low, the next `pix_en` edge loads the reset state and the block holds there.
  - While stopped, the divider keeps running.
  - When `enable` returns high, the next tick moves the raster to (0,0) and `frame_start` fires.
- Elaboration checks: H_TOTAL and V_TOTAL must be ≤ 2^CW, and every parameter must be ≥ 1. A violation raises a `$error`.

## Timing
- Reset values, applied asynchronously while `reset_n` is low:
  - `div_cnt`=0, `pix_en`=0
  - `h_count`=H_TOTAL-1, `v_count`=V_TOTAL-1
  - `h_sync`=!H_POL, `v_sync`=!V_POL
  - `bright`=0, `line_start`=0, `frame_start`=0
  - all delay stages hold the inactive values
- First `pix_en` occurs CLK_DIV-1 clocks after `reset_n` deasserts.
- The first tick with `enable` high moves the raster to (0,0), and `frame_start` fires.
- Output updates land on the `pix_en` edge and are held for CLK_DIV clocks.
- Asserting `reset_n` mid-frame returns every output to its reset value immediately. There is no partial-frame recovery.

## Structure
- Package `vga_timing_pkg`:
  - 640x480@60 constants, as the default parameter values
  - 800x600 and 320x240 parameter sets
  - a function returning H_TOTAL/V_TOTAL
  - a typedef for the `{hs, vs, bright}` struct
- Sub-module `vga_sync_delay`: parametrised PIPE-stage, enable-gated shift register. With PIPE=0 it is a wire.

## Test plan
- Reset check: hold `reset_n` low with default parameters. Required: `h_count`=799, `v_count`=524, `h_sync`=1, `v_sync`=1, `bright`=0, `pix_en`=0.
- Default parameters, CLK_DIV=2:
  - `pix_en` is high every second clock.
  - `h_sync` is low for h 656..751, i.e. 192 clocks.
  - Line period is 1600 clocks; frame period is 840000 clocks.
  - `frame_start` fires once per frame.
- Per-frame counts, default parameters:
  - `v_sync` is low only on lines 490..491.
  - Exactly 307200 `pix_en` ticks per frame have `bright`=1.
  - 525 `line_start` pulses per frame.
- PIPE=3: `h_sync` falls 3 `pix_en` ticks (6 clocks) after `h_count` becomes 656. `bright` falls 3 ticks after `h_count` becomes 640.
- Small raster, exact waveform:
  - Parameters: H=4/1/2/1, V=3/1/1/1, H_POL=V_POL=1, CLK_DIV=1.
  - `h_sync` is high at h 5..6.
  - `v_sync` is high on line 4 only.
  - Frame length is 48 clocks.
- Control and reset mid-operation:
  - Drop `enable` at (300,100). Required: the next tick restores the reset state and it holds.
  - Raise `enable`. Required: the next tick gives (0,0) with `frame_start`=1.
  - Pulse `reset_n` low mid-line. Required: immediate reset values.
